// File: rtl/dom_indep_mul_gf2n_hs_if.sv
// dom_indep_mul_gf2n_hs_if: operand, randomness and result handshakes of the masked GF(2^N) multiplier
interface dom_indep_mul_gf2n_hs_if #(
   parameter int N      = 4,
   parameter int SHARES = 2
);
   localparam int NZ = N * SHARES * (SHARES - 1) / 2;
   logic                  InValidxSI;
   logic                  InReadyxSO;
   logic [N*SHARES-1:0]   XxDI;
   logic [N*SHARES-1:0]   YxDI;
   logic                  ZValidxSI;
   logic [NZ-1:0]         ZxDI;
   logic                  ZReadyxSO;
   logic                  OutValidxSO;
   logic                  OutReadyxSI;
   logic [N*SHARES-1:0]   QxDO;
   modport master (
      output InValidxSI, XxDI, YxDI, ZValidxSI, ZxDI, OutReadyxSI,
      input  InReadyxSO, ZReadyxSO, OutValidxSO, QxDO
   );
   modport slave (
      input  InValidxSI, XxDI, YxDI, ZValidxSI, ZxDI, OutReadyxSI,
      output InReadyxSO, ZReadyxSO, OutValidxSO, QxDO
   );
endinterface

// File: rtl/dom_indep_mul_gf2n_hs.sv
// dom_indep_mul_gf2n_hs: DOM-indep masked GF(2^N) multiplier, any share count, valid/ready flow control
module dom_indep_mul_gf2n_hs #(
   parameter int         N         = 4,
   parameter logic [N:0] POLY      = 5'h13,
   parameter int         SHARES    = 2,
   parameter bit         PIPELINED = 1
) (
   input logic                   ClkxCI,
   input logic                   RstxSI,
   dom_indep_mul_gf2n_hs_if.slave bus
);
   function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N-1:0] acc;
      logic [N-1:0] sh;
      acc = '0;
      sh  = a;
      for (int k = 0; k < N; k++) begin
         if (b[k]) acc = acc ^ sh;
         sh = sh[N-1] ? ({sh[N-2:0], 1'b0} ^ POLY[N-1:0]) : {sh[N-2:0], 1'b0};
      end
      return acc;
   endfunction

   function automatic int pair_idx(input int lo, input int hi);
      return lo * SHARES - lo * (lo + 1) / 2 + hi - lo - 1;
   endfunction

   logic [N-1:0]        term [SHARES][SHARES];
   logic [N-1:0]        r1   [SHARES][SHARES];
   logic [N*SHARES-1:0] q1;
   logic                v1;
   logic                adv1;
   logic                in_ready;
   logic                fire;

   assign in_ready       = ~v1 | adv1;
   assign fire           = bus.InValidxSI & bus.ZValidxSI & in_ready & ~RstxSI;
   assign bus.InReadyxSO = in_ready;
   assign bus.ZReadyxSO  = fire;

   // share products; cross terms are masked by their pair's fresh Z before being registered
   always_comb begin
      for (int i = 0; i < SHARES; i++) begin
         for (int j = 0; j < SHARES; j++) begin
            term[i][j] = gf_mul(bus.XxDI[i*N +: N], bus.YxDI[j*N +: N]);
            if (i < j) term[i][j] = term[i][j] ^ bus.ZxDI[pair_idx(i, j)*N +: N];
            if (i > j) term[i][j] = term[i][j] ^ bus.ZxDI[pair_idx(j, i)*N +: N];
         end
      end
   end

   // resharing register: every inner and cross term held separately, loaded only on fire
   always_ff @(posedge ClkxCI) begin
      if (RstxSI) begin
         v1 <= 1'b0;
         for (int i = 0; i < SHARES; i++)
            for (int j = 0; j < SHARES; j++)
               r1[i][j] <= '0;
      end else begin
         v1 <= fire | (v1 & ~adv1);
         if (fire)
            for (int i = 0; i < SHARES; i++)
               for (int j = 0; j < SHARES; j++)
                  r1[i][j] <= term[i][j];
      end
   end

   // domain compression after the register: Q_i = I_i ^ XOR of row i's cross terms
   always_comb begin
      q1 = '0;
      for (int i = 0; i < SHARES; i++)
         for (int j = 0; j < SHARES; j++)
            q1[i*N +: N] = q1[i*N +: N] ^ r1[i][j];
   end

   generate
      if (PIPELINED) begin : g_pipe
         logic                v2;
         logic                ld2;
         logic [N*SHARES-1:0] q2;
         assign ld2             = v1 & (~v2 | bus.OutReadyxSI);
         assign adv1            = ld2;
         assign bus.OutValidxSO = v2;
         assign bus.QxDO        = q2;
         // output register: refills in the same cycle its content is taken downstream
         always_ff @(posedge ClkxCI) begin
            if (RstxSI) begin
               v2 <= 1'b0;
               q2 <= '0;
            end else begin
               v2 <= ld2 | (v2 & ~bus.OutReadyxSI);
               if (ld2) q2 <= q1;
            end
         end
      end else begin : g_comb
         assign adv1            = v1 & bus.OutReadyxSI;
         assign bus.OutValidxSO = v1;
         assign bus.QxDO        = q1;
      end
   endgenerate
endmodule

// File: tb/tb_dom_indep_mul_gf2n_hs.sv
// tb_dom_indep_mul_gf2n_hs: scoreboard bench for two multiplier configurations
module tb_dom_indep_mul_gf2n_hs;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int qa[$];
   int qb[$];

   dom_indep_mul_gf2n_hs_if #(.N(4), .SHARES(2)) a_if();
   dom_indep_mul_gf2n_hs_if #(.N(8), .SHARES(3)) b_if();

   dom_indep_mul_gf2n_hs #(.N(4), .POLY(5'h13), .SHARES(2), .PIPELINED(1)) dut_a (
      .ClkxCI(clk), .RstxSI(rst), .bus(a_if.slave));
   dom_indep_mul_gf2n_hs #(.N(8), .POLY(9'h11B), .SHARES(3), .PIPELINED(0)) dut_b (
      .ClkxCI(clk), .RstxSI(rst), .bus(b_if.slave));

   // carry-less product followed by polynomial long division
   function automatic int gfm(input int a, input int b, input int poly, input int n);
      int p = 0;
      for (int k = 0; k < n; k++) if (((b >> k) & 1) != 0) p ^= a << k;
      for (int k = 2 * n - 2; k >= n; k--) if (((p >> k) & 1) != 0) p ^= poly << (k - n);
      return p;
   endfunction

   function automatic int xs(input logic [63:0] v, input int n, input int s);
      int r = 0;
      for (int i = 0; i < s; i++) r ^= int'((v >> (i * n)) & ((64'd1 << n) - 64'd1));
      return r;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int model_a();
      return gfm(xs(a_if.XxDI, 4, 2), xs(a_if.YxDI, 4, 2), 'h13, 4);
   endfunction

   function automatic int model_b();
      return gfm(xs(b_if.XxDI, 8, 3), xs(b_if.YxDI, 8, 3), 'h11B, 8);
   endfunction

   task automatic rand_a();
      a_if.XxDI = 8'($urandom);
      a_if.YxDI = 8'($urandom);
      a_if.ZxDI = 4'($urandom);
   endtask

   task automatic rand_b();
      b_if.XxDI = 24'($urandom);
      b_if.YxDI = 24'($urandom);
      b_if.ZxDI = 24'($urandom);
   endtask

   task automatic send_a(input logic [7:0] x, input logic [7:0] y, input logic [3:0] z, input int exp);
      a_if.XxDI = x;
      a_if.YxDI = y;
      a_if.ZxDI = z;
      a_if.InValidxSI = 1'b1;
      a_if.ZValidxSI  = 1'b1;
      for (int c = 0; c < 64; c++) begin
         #1;
         if (a_if.ZReadyxSO) begin
            qa.push_back(exp);
            @(negedge clk);
            return;
         end
         @(negedge clk);
      end
      chk("a_send_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      a_if.InValidxSI = 1'b0;
      a_if.ZValidxSI  = 1'b0;
      b_if.InValidxSI = 1'b0;
      b_if.ZValidxSI  = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // monitor A: pops expected results and checks stall stability
   logic [7:0] held_a;
   bit         hold_a = 1'b0;
   always begin
      @(negedge clk);
      #2;
      if (rst) hold_a = 1'b0;
      else begin
         if (hold_a) begin
            chk("a_stall_q", int'(a_if.QxDO), int'(held_a));
            chk("a_stall_valid", int'(a_if.OutValidxSO), 1);
         end
         if (a_if.OutValidxSO && a_if.OutReadyxSI) begin
            if (qa.size() == 0) chk("a_unexpected_out", 1, 0);
            else chk("a_result", xs(a_if.QxDO, 4, 2), qa.pop_front());
         end
         hold_a = a_if.OutValidxSO && !a_if.OutReadyxSI;
         held_a = a_if.QxDO;
      end
   end

   // monitor B: pops expected results and checks stall stability
   logic [23:0] held_b;
   bit          hold_b = 1'b0;
   always begin
      @(negedge clk);
      #2;
      if (rst) hold_b = 1'b0;
      else begin
         if (hold_b) begin
            chk("b_stall_q", int'(b_if.QxDO), int'(held_b));
            chk("b_stall_valid", int'(b_if.OutValidxSO), 1);
         end
         if (b_if.OutValidxSO && b_if.OutReadyxSI) begin
            if (qb.size() == 0) chk("b_unexpected_out", 1, 0);
            else chk("b_result", xs(b_if.QxDO, 8, 3), qb.pop_front());
         end
         hold_b = b_if.OutValidxSO && !b_if.OutReadyxSI;
         held_b = b_if.QxDO;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   initial begin
      int k;
      logic [7:0] ox [3];
      logic [7:0] oy [3];
      a_if.XxDI = '0; a_if.YxDI = '0; a_if.ZxDI = '0;
      b_if.XxDI = '0; b_if.YxDI = '0; b_if.ZxDI = '0;
      a_if.InValidxSI = 1'b1; a_if.ZValidxSI = 1'b1; a_if.OutReadyxSI = 1'b1;
      b_if.InValidxSI = 1'b1; b_if.ZValidxSI = 1'b1; b_if.OutReadyxSI = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("a_zready_in_reset", int'(a_if.ZReadyxSO), 0);
      chk("b_zready_in_reset", int'(b_if.ZReadyxSO), 0);
      @(negedge clk);
      rst = 1'b0;
      a_if.InValidxSI = 1'b0; a_if.ZValidxSI = 1'b0;
      b_if.InValidxSI = 1'b0; b_if.ZValidxSI = 1'b0;
      #1;
      chk("a_reset_outvalid", int'(a_if.OutValidxSO), 0);
      chk("a_reset_q", int'(a_if.QxDO), 0);
      chk("a_reset_inready", int'(a_if.InReadyxSO), 1);
      chk("b_reset_outvalid", int'(b_if.OutValidxSO), 0);
      chk("b_reset_q", int'(b_if.QxDO), 0);
      chk("b_reset_inready", int'(b_if.InReadyxSO), 1);
      @(negedge clk);

      // known answer 3*5 = F with latency 2
      a_if.XxDI = 8'h21; a_if.YxDI = 8'h14; a_if.ZxDI = 4'hA;
      a_if.InValidxSI = 1'b1; a_if.ZValidxSI = 1'b1;
      #1;
      chk("a_kat_zready", int'(a_if.ZReadyxSO), 1);
      if (a_if.ZReadyxSO) qa.push_back('hF);
      @(negedge clk);
      a_if.InValidxSI = 1'b0; a_if.ZValidxSI = 1'b0;
      #1;
      chk("a_latency_t1", int'(a_if.OutValidxSO), 0);
      @(negedge clk);
      #1;
      chk("a_latency_t2", int'(a_if.OutValidxSO), 1);
      @(negedge clk);
      send_a(8'hD5, 8'h57, 4'h6, 'h3);
      idle(4);

      // randomness starvation holds the operands back
      a_if.XxDI = 8'h21; a_if.YxDI = 8'h14; a_if.ZxDI = 4'h3;
      a_if.InValidxSI = 1'b1; a_if.ZValidxSI = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("a_starve_zready", int'(a_if.ZReadyxSO), 0);
         chk("a_starve_outvalid", int'(a_if.OutValidxSO), 0);
         @(negedge clk);
      end
      a_if.ZValidxSI = 1'b1;
      #1;
      chk("a_starve_release", int'(a_if.ZReadyxSO), 1);
      if (a_if.ZReadyxSO) qa.push_back('hF);
      @(negedge clk);
      idle(4);

      // back-pressure: two accepted, then full
      for (int i = 0; i < 3; i++) begin
         ox[i] = 8'($urandom);
         oy[i] = 8'($urandom);
      end
      a_if.OutReadyxSI = 1'b0;
      k = 0;
      for (int c = 0; c < 6; c++) begin
         a_if.XxDI = ox[k % 3]; a_if.YxDI = oy[k % 3]; a_if.ZxDI = 4'($urandom);
         a_if.InValidxSI = (k < 3); a_if.ZValidxSI = 1'b1;
         #1;
         if (a_if.ZReadyxSO) begin qa.push_back(model_a()); k++; end
         @(negedge clk);
      end
      chk("a_bp_accepted", k, 2);
      #1;
      chk("a_bp_inready", int'(a_if.InReadyxSO), 0);
      @(negedge clk);
      a_if.OutReadyxSI = 1'b1;
      for (int c = 0; c < 20 && k < 3; c++) begin
         a_if.XxDI = ox[k]; a_if.YxDI = oy[k];
         a_if.InValidxSI = 1'b1;
         #1;
         if (a_if.ZReadyxSO) begin qa.push_back(model_a()); k++; end
         @(negedge clk);
      end
      chk("a_bp_third", k, 3);
      idle(5);
      chk("a_bp_drain", qa.size(), 0);

      // reset one cycle after fire discards the result
      send_a(8'h21, 8'h14, 4'h1, 'hF);
      rst = 1'b1;
      void'(qa.pop_back());
      #1;
      chk("a_zready_mid_reset", int'(a_if.ZReadyxSO), 0);
      @(negedge clk);
      rst = 1'b0;
      a_if.InValidxSI = 1'b0; a_if.ZValidxSI = 1'b0;
      #1;
      chk("a_post_reset_outvalid", int'(a_if.OutValidxSO), 0);
      chk("a_post_reset_q", int'(a_if.QxDO), 0);
      chk("a_post_reset_inready", int'(a_if.InReadyxSO), 1);
      @(negedge clk);
      idle(4);

      // continuous traffic: one accept per cycle
      for (int c = 0; c < 20; c++) begin
         rand_a();
         a_if.InValidxSI = 1'b1; a_if.ZValidxSI = 1'b1;
         #1;
         chk("a_throughput", int'(a_if.ZReadyxSO), 1);
         if (a_if.ZReadyxSO) qa.push_back(model_a());
         @(negedge clk);
      end

      // random traffic with random starvation and back-pressure
      for (int c = 0; c < 400; c++) begin
         rand_a();
         a_if.InValidxSI  = ($urandom_range(0, 3) != 0);
         a_if.ZValidxSI   = ($urandom_range(0, 3) != 0);
         a_if.OutReadyxSI = ($urandom_range(0, 9) < 7);
         #1;
         chk("a_zready_is_fire", int'(a_if.ZReadyxSO),
             int'(a_if.InValidxSI & a_if.ZValidxSI & a_if.InReadyxSO));
         if (a_if.ZReadyxSO) qa.push_back(model_a());
         @(negedge clk);
      end
      a_if.OutReadyxSI = 1'b1;
      idle(6);
      chk("a_final_drain", qa.size(), 0);

      // B: known answer 57*83 = C1 with latency 1
      b_if.XxDI = 24'h642211; b_if.YxDI = 24'h7CF00F; b_if.ZxDI = 24'hA53C96;
      b_if.InValidxSI = 1'b1; b_if.ZValidxSI = 1'b1;
      #1;
      chk("b_kat_zready", int'(b_if.ZReadyxSO), 1);
      if (b_if.ZReadyxSO) qb.push_back('hC1);
      @(negedge clk);
      b_if.InValidxSI = 1'b0; b_if.ZValidxSI = 1'b0;
      #1;
      chk("b_latency_t1", int'(b_if.OutValidxSO), 1);
      @(negedge clk);
      idle(2);

      for (int c = 0; c < 20; c++) begin
         rand_b();
         b_if.InValidxSI = 1'b1; b_if.ZValidxSI = 1'b1;
         #1;
         chk("b_throughput", int'(b_if.ZReadyxSO), 1);
         if (b_if.ZReadyxSO) qb.push_back(model_b());
         @(negedge clk);
      end

      for (int c = 0; c < 400; c++) begin
         rand_b();
         b_if.InValidxSI  = ($urandom_range(0, 3) != 0);
         b_if.ZValidxSI   = ($urandom_range(0, 3) != 0);
         b_if.OutReadyxSI = ($urandom_range(0, 9) < 7);
         #1;
         chk("b_zready_is_fire", int'(b_if.ZReadyxSO),
             int'(b_if.InValidxSI & b_if.ZValidxSI & b_if.InReadyxSO));
         if (b_if.ZReadyxSO) qb.push_back(model_b());
         @(negedge clk);
      end
      b_if.OutReadyxSI = 1'b1;
      idle(6);
      chk("b_final_drain", qb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
